// File: rtl/mem_1r1w_ctrl_if.sv
// Requester, writer and memory-side signals of the mem_1r1w controller.
// slave = controller side, master = requesters plus the memory macro.
interface mem_1r1w_ctrl_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_ADDR = 8,
  parameter int WIDTH_DATA = 8
);
  logic                          init_done;
  logic                          wr_valid;
  logic                          wr_ready;
  logic [WIDTH_ADDR-1:0]         wr_addr;
  logic [WIDTH_DATA-1:0]         wr_data;
  logic [NUM_REQ-1:0]            rd_valid;
  logic [NUM_REQ-1:0]            rd_ready;
  logic [NUM_REQ*WIDTH_ADDR-1:0] rd_addr;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [WIDTH_DATA-1:0]         rsp_data;
  logic                          mem_wen;
  logic [WIDTH_ADDR-1:0]         mem_waddr;
  logic [WIDTH_DATA-1:0]         mem_din;
  logic                          mem_ren;
  logic [WIDTH_ADDR-1:0]         mem_raddr;
  logic [WIDTH_DATA-1:0]         mem_dout;

  modport slave (
    output init_done, wr_ready, rd_ready, rsp_valid, rsp_data,
           mem_wen, mem_waddr, mem_din, mem_ren, mem_raddr,
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_dout
  );

  modport master (
    input  init_done, wr_ready, rd_ready, rsp_valid, rsp_data,
           mem_wen, mem_waddr, mem_din, mem_ren, mem_raddr,
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_dout
  );
endinterface

// File: rtl/mem_1r1w_ctrl.sv
// Single-clock mem_1r1w controller: post-reset clear sweep, writer pass-through,
// round-robin shared read port with in-order one-hot tagged responses.
module mem_1r1w_ctrl #(
  parameter int                   NUM_REQ    = 4,
  parameter int                   WIDTH_ADDR = 8,
  parameter int                   WIDTH_DATA = 8,
  parameter int                   RD_LATENCY = 1,
  parameter int                   INIT_EN    = 1,
  parameter logic [WIDTH_DATA-1:0] INIT_VALUE = '0
) (
  input  logic            clk,
  input  logic            rst,
  mem_1r1w_ctrl_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                                 r_state, w_state_nxt;
  logic [WIDTH_ADDR-1:0]                  r_init_addr;
  logic [PTR_W-1:0]                       r_rr_ptr;
  logic [RD_LATENCY-1:0][NUM_REQ-1:0]     r_tag;

  logic [PTR_W-1:0]      w_cand;
  logic                  w_found;
  logic [WIDTH_ADDR-1:0] w_cand_addr;
  logic                  w_collide;
  logic                  w_grant;
  logic [NUM_REQ-1:0]    w_rd_ready;
  logic [PTR_W-1:0]      w_ptr_nxt;

  // first requesting index at or after rr_ptr, modulo NUM_REQ
  always_comb begin
    int v_idx;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && bus.rd_valid[v_idx]) begin
        w_found = 1'b1;
        w_cand  = PTR_W'(v_idx);
      end
    end
  end

  assign w_cand_addr = bus.rd_addr[int'(w_cand)*WIDTH_ADDR +: WIDTH_ADDR];
  // a same-cycle write to the read address wins; the read retries next cycle
  assign w_collide   = bus.wr_valid && (w_cand_addr == bus.wr_addr);
  assign w_grant     = (r_state == S_RUN) && w_found && !w_collide;
  assign w_rd_ready  = w_grant ? (NUM_REQ'(1) << w_cand) : '0;
  assign w_ptr_nxt   = (w_cand == PTR_W'(NUM_REQ-1)) ? '0 : w_cand + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= (INIT_EN != 0) ? S_INIT : S_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && r_init_addr == '1) w_state_nxt = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_addr <= '0;
      r_rr_ptr    <= '0;
      r_tag       <= '0;
    end else begin
      if (r_state == S_INIT) r_init_addr <= r_init_addr + 1'b1;
      if (w_grant)           r_rr_ptr    <= w_ptr_nxt;
      r_tag[0] <= w_rd_ready & bus.rd_valid;
      for (int s = 1; s < RD_LATENCY; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  always_comb begin
    bus.init_done = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.rd_ready  = '0;
    bus.mem_wen   = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_din   = '0;
    bus.mem_ren   = 1'b0;
    bus.mem_raddr = '0;
    bus.rsp_valid = '0;
    bus.rsp_data  = bus.mem_dout;
    if (!rst) begin
      bus.rsp_valid = r_tag[RD_LATENCY-1];
      case (r_state)
        S_INIT: begin
          bus.mem_wen   = 1'b1;
          bus.mem_waddr = r_init_addr;
          bus.mem_din   = INIT_VALUE;
        end
        S_RUN: begin
          bus.init_done = 1'b1;
          bus.wr_ready  = 1'b1;
          bus.mem_wen   = bus.wr_valid;
          bus.mem_waddr = bus.wr_addr;
          bus.mem_din   = bus.wr_data;
          bus.rd_ready  = w_rd_ready;
          bus.mem_ren   = w_grant;
          bus.mem_raddr = w_cand_addr;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_1r1w_ctrl.sv
// Bench: two controllers (read latency 1 and 2) on shared stimulus, each with a
// behavioural memory; responses are scored against a reference memory image.
module tb_mem_1r1w_ctrl;
  localparam int NR = 4;
  localparam int WA = 4;
  localparam int WD = 8;
  localparam int DEPTH = 1 << WA;
  localparam logic [WD-1:0] IV = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              wr_valid = 1'b0;
  logic [WA-1:0]     wr_addr  = '0;
  logic [WD-1:0]     wr_data  = '0;
  logic [NR-1:0]     rd_valid = '0;
  logic [NR*WA-1:0]  rd_addr  = '0;

  mem_1r1w_ctrl_if #(.NUM_REQ(NR), .WIDTH_ADDR(WA), .WIDTH_DATA(WD)) ifa ();
  mem_1r1w_ctrl_if #(.NUM_REQ(NR), .WIDTH_ADDR(WA), .WIDTH_DATA(WD)) ifb ();

  mem_1r1w_ctrl #(.NUM_REQ(NR), .WIDTH_ADDR(WA), .WIDTH_DATA(WD), .RD_LATENCY(1),
                  .INIT_EN(1), .INIT_VALUE(IV))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mem_1r1w_ctrl #(.NUM_REQ(NR), .WIDTH_ADDR(WA), .WIDTH_DATA(WD), .RD_LATENCY(2),
                  .INIT_EN(1), .INIT_VALUE(IV))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  assign ifa.wr_valid = wr_valid;  assign ifb.wr_valid = wr_valid;
  assign ifa.wr_addr  = wr_addr;   assign ifb.wr_addr  = wr_addr;
  assign ifa.wr_data  = wr_data;   assign ifb.wr_data  = wr_data;
  assign ifa.rd_valid = rd_valid;  assign ifb.rd_valid = rd_valid;
  assign ifa.rd_addr  = rd_addr;   assign ifb.rd_addr  = rd_addr;

  // behavioural mem_1r1w: A without output register, B with
  logic [WD-1:0] mem_a [DEPTH];
  logic [WD-1:0] mem_b [DEPTH];
  logic [WD-1:0] q_b;
  always @(posedge clk) begin
    if (ifa.mem_wen) mem_a[ifa.mem_waddr] <= ifa.mem_din;
    if (ifa.mem_ren) ifa.mem_dout <= mem_a[ifa.mem_raddr];
    if (ifb.mem_wen) mem_b[ifb.mem_waddr] <= ifb.mem_din;
    if (ifb.mem_ren) q_b <= mem_b[ifb.mem_raddr];
    ifb.mem_dout <= q_b;
  end

  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [NR-1:0] tag; logic [WD-1:0] data; int due; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  logic [WD-1:0] ref_mem [DEPTH];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: push on accepted reads, pop on response strobes
  always @(negedge clk) begin
    exp_t e;
    logic [NR-1:0] g;
    int gi;
    if (rst) begin
      chk("rst_rsp_a", 32'(ifa.rsp_valid), 0);
      chk("rst_rsp_b", 32'(ifb.rsp_valid), 0);
      qa.delete();
      qb.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] <= IV;
    end else begin
      if (ifa.rsp_valid != 0) begin
        if (qa.size() == 0) chk("rsp_unexp_a", 32'(ifa.rsp_valid), 0);
        else begin
          e = qa.pop_front();
          chk("rsp_tag_a", 32'(ifa.rsp_valid), 32'(e.tag));
          chk("rsp_data_a", 32'(ifa.rsp_data), 32'(e.data));
          chk("rsp_lat_a", cyc, e.due);
        end
      end else if (qa.size() > 0 && qa[0].due <= cyc) begin
        chk("rsp_miss_a", 0, 32'(qa[0].tag));
        void'(qa.pop_front());
      end
      if (ifb.rsp_valid != 0) begin
        if (qb.size() == 0) chk("rsp_unexp_b", 32'(ifb.rsp_valid), 0);
        else begin
          e = qb.pop_front();
          chk("rsp_tag_b", 32'(ifb.rsp_valid), 32'(e.tag));
          chk("rsp_data_b", 32'(ifb.rsp_data), 32'(e.data));
          chk("rsp_lat_b", cyc, e.due);
        end
      end else if (qb.size() > 0 && qb[0].due <= cyc) begin
        chk("rsp_miss_b", 0, 32'(qb[0].tag));
        void'(qb.pop_front());
      end
      g = ifa.rd_ready & rd_valid;
      if (g != 0) begin
        gi = 0;
        for (int i = NR-1; i >= 0; i--) if (g[i]) gi = i;
        e.tag = g; e.data = ref_mem[rd_addr[gi*WA +: WA]]; e.due = cyc + 1;
        qa.push_back(e);
      end
      g = ifb.rd_ready & rd_valid;
      if (g != 0) begin
        gi = 0;
        for (int i = NR-1; i >= 0; i--) if (g[i]) gi = i;
        e.tag = g; e.data = ref_mem[rd_addr[gi*WA +: WA]]; e.due = cyc + 2;
        qb.push_back(e);
      end
      if (wr_valid && ifa.wr_ready) ref_mem[wr_addr] <= wr_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic clr();
    rd_valid = '0; wr_valid = 1'b0;
  endtask
  task automatic set_rd(input int r, input logic [WA-1:0] a);
    rd_addr[r*WA +: WA] = a;
    rd_valid[r] = 1'b1;
  endtask
  task automatic set_wr(input logic [WA-1:0] a, input logic [WD-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
  endtask
  task automatic drain();
    clr(); repeat (3) tick();
  endtask
  task automatic chk_rdy(input string tag, input logic [NR-1:0] exp);
    @(negedge clk);
    chk({tag, "_a"}, 32'(ifa.rd_ready), 32'(exp));
    chk({tag, "_b"}, 32'(ifb.rd_ready), 32'(exp));
  endtask

  initial begin
    // reset state, with requests present that must not be granted
    rd_valid = '1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_init_done", 32'(ifa.init_done), 0);
    chk("rst_wr_ready", 32'(ifa.wr_ready), 0);
    chk("rst_rd_ready", 32'(ifb.rd_ready), 0);
    chk("rst_mem_wen", 32'(ifa.mem_wen), 0);
    chk("rst_mem_ren", 32'(ifb.mem_ren), 0);
    clr();
    tick(); rst = 1'b0;

    // init sweep of 16 addresses, then RUN
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("init_wen", 32'(ifa.mem_wen), 1);
      chk("init_waddr", 32'(ifa.mem_waddr), i);
      chk("init_din", 32'(ifb.mem_din), 32'(IV));
      chk("init_done_lo", 32'(ifb.init_done), 0);
      chk("init_wr_ready", 32'(ifa.wr_ready), 0);
    end
    @(negedge clk);
    chk("init_done_a", 32'(ifa.init_done), 1);
    chk("init_done_b", 32'(ifb.init_done), 1);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      clr(); set_rd(0, WA'(i)); tick();
    end
    drain();

    // single read after write
    set_wr(3, 8'h11); tick(); clr();
    set_rd(0, 3);
    chk_rdy("t2_grant", 4'b0001);
    tick(); drain();

    // round robin: align rr_ptr to 0, then all four requesting
    for (int i = 0; i < NR; i++) begin set_wr(WA'(i), 8'h20 + 8'(i)); tick(); end
    clr(); set_rd(3, 0); tick(); clr();
    for (int i = 0; i < NR; i++) set_rd(i, WA'(i));
    for (int k = 0; k < 8; k++) begin
      chk_rdy("t3_rr", NR'(1) << (k % NR));
      tick();
    end
    drain();

    // collision stall then retry returns new data
    set_wr(5, 8'h77); set_rd(2, 5);
    chk_rdy("t4_stall", '0);
    chk("t4_ren_a", 32'(ifa.mem_ren), 0);
    chk("t4_wen_a", 32'(ifa.mem_wen), 1);
    tick(); wr_valid = 1'b0;
    chk_rdy("t4_retry", 4'b0100);
    tick(); drain();

    // concurrent reads and non-colliding writes: no stalls
    set_rd(1, 1); set_rd(3, 3); set_wr(8, 8'h88);
    chk_rdy("t5_g0", 4'b1000);
    chk("t5_wen0", 32'(ifb.mem_wen), 1);
    tick(); set_wr(9, 8'h99);
    chk_rdy("t5_g1", 4'b0010);
    chk("t5_wen1", 32'(ifb.mem_wen), 1);
    tick(); clr();
    set_rd(0, 8); tick();
    set_rd(0, 9); tick();
    drain();

    // reset with reads in flight: responses discarded, init restarts
    set_rd(0, 3); tick(); clr();
    set_rd(1, 4); tick(); clr();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_init_done", 32'(ifb.init_done), 0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t6_wen", 32'(ifa.mem_wen), 1);
    chk("t6_waddr", 32'(ifb.mem_waddr), 0);
    chk("t6_init_done_lo", 32'(ifa.init_done), 0);
    repeat (DEPTH) @(posedge clk);
    @(negedge clk);
    chk("t6_init_done_hi", 32'(ifb.init_done), 1);
    tick();
    set_rd(2, 3); tick();
    drain();

    chk("end_q_a", qa.size(), 0);
    chk("end_q_b", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
